// File: rtl/ahb_slave_mux.sv
// AHB-Lite data-phase response multiplexer for three slaves plus a built-in default slave.
// Unmapped NONSEQ/SEQ transfers receive a two-cycle ERROR response and are counted (saturating).
module ahb_slave_mux #(
  parameter int DATA_W    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 HSEL_1,
  input  logic                 HSEL_2,
  input  logic                 HSEL_3,
  input  logic                 HSEL_DF,
  input  logic [1:0]           HTRANS,
  input  logic [DATA_W-1:0]    HRDATA_1,
  input  logic [DATA_W-1:0]    HRDATA_2,
  input  logic [DATA_W-1:0]    HRDATA_3,
  input  logic                 HREADYOUT_1,
  input  logic                 HREADYOUT_2,
  input  logic                 HREADYOUT_3,
  input  logic                 HRESP_1,
  input  logic                 HRESP_2,
  input  logic                 HRESP_3,
  output logic [DATA_W-1:0]    HRDATA,
  output logic                 HREADY,
  output logic                 HRESP,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam int NUM_SLV = 3;

  typedef enum logic [1:0] {
    DF_OK   = 2'd0,
    DF_ERR1 = 2'd1,
    DF_ERR2 = 2'd2
  } df_state_t;

  // Selection is one-hot {S1, S2, S3, DF}; bit 0 is the default slave.
  logic [3:0]           sel_reg;
  logic [3:0]           sel_next;
  df_state_t            df_state_reg;
  df_state_t            df_state_next;
  logic [ERR_CNT_W-1:0] err_cnt_reg;
  logic [ERR_CNT_W-1:0] err_cnt_next;

  logic                 htrans_active;
  logic                 df_err_start;
  logic                 df_ready;
  logic                 df_resp;

  logic [DATA_W-1:0]    slv_rdata [NUM_SLV];
  logic [NUM_SLV-1:0]   slv_ready;
  logic [NUM_SLV-1:0]   slv_resp;
  logic [NUM_SLV-1:0]   slv_sel;
  logic [DATA_W-1:0]    rdata_term [NUM_SLV];

  assign slv_rdata[0] = HRDATA_1;
  assign slv_rdata[1] = HRDATA_2;
  assign slv_rdata[2] = HRDATA_3;
  assign slv_ready    = {HREADYOUT_3, HREADYOUT_2, HREADYOUT_1};
  assign slv_resp     = {HRESP_3, HRESP_2, HRESP_1};

  assign htrans_active = (HTRANS == 2'b10) || (HTRANS == 2'b11);

  // Address-phase winner; nothing selected falls through to the default slave.
  always_comb begin
    sel_next = 4'b0001;
    if (HSEL_1) begin
      sel_next = 4'b1000;
    end else if (HSEL_2) begin
      sel_next = 4'b0100;
    end else if (HSEL_3) begin
      sel_next = 4'b0010;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_reg <= 4'b0001;
    end else if (HREADY) begin
      sel_reg <= sel_next;
    end
  end

  // Default-slave FSM and error counter.
  assign df_err_start = HREADY && sel_next[0] && htrans_active;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      df_state_reg <= DF_OK;
      err_cnt_reg  <= '0;
    end else begin
      df_state_reg <= df_state_next;
      err_cnt_reg  <= err_cnt_next;
    end
  end

  always_comb begin
    df_state_next = df_state_reg;
    err_cnt_next  = err_cnt_reg;
    df_ready      = 1'b1;
    df_resp       = 1'b0;
    case (df_state_reg)
      DF_OK, DF_ERR2: begin
        df_resp = (df_state_reg == DF_ERR2);
        if (df_err_start) begin
          df_state_next = DF_ERR1;
          if (err_cnt_reg != {ERR_CNT_W{1'b1}}) begin
            err_cnt_next = err_cnt_reg + ERR_CNT_W'(1);
          end
        end else begin
          df_state_next = DF_OK;
        end
      end
      DF_ERR1: begin
        df_ready      = 1'b0;
        df_resp       = 1'b1;
        df_state_next = DF_ERR2;
      end
      default: begin
        df_state_next = DF_OK;
      end
    endcase
  end

  // AND-OR mux over the one-hot selection; the default slave contributes zero data.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLV; gi++) begin : g_slv
      assign slv_sel[gi]    = sel_reg[3-gi];
      assign rdata_term[gi] = slv_sel[gi] ? slv_rdata[gi] : '0;
    end
  endgenerate

  always_comb begin
    HRDATA = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      HRDATA = HRDATA | rdata_term[i];
    end
  end

  always_comb begin
    if (sel_reg[0]) begin
      HREADY = df_ready;
      HRESP  = df_resp;
    end else begin
      HREADY = |(slv_ready & slv_sel);
      HRESP  = |(slv_resp & slv_sel);
    end
  end

  assign ERR_CNT = err_cnt_reg;

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Self-checking bench for ahb_slave_mux: directed scenarios plus randomized traffic
// compared against a transaction-level model of the data phase.
module tb_ahb_slave_mux;

  logic        HCLK;
  logic        HRESETn;
  logic        hsel_1, hsel_2, hsel_3, hsel_df;
  logic [1:0]  htrans;
  logic [31:0] rdata_1, rdata_2, rdata_3;
  logic        ready_1, ready_2, ready_3;
  logic        resp_1, resp_2, resp_3;
  logic [31:0] hrdata;
  logic        hready, hresp;
  logic [7:0]  err_cnt;
  logic [31:0] hrdata_s;
  logic        hready_s, hresp_s;
  logic [1:0]  err_cnt_s;

  int checks = 0;
  int errors = 0;

  // Model: who owns the current data phase (0 = default slave), error cycles left, error total.
  int m_tgt = 0;
  int m_err = 0;
  int m_cnt = 0;

  ahb_slave_mux #(.DATA_W(32), .ERR_CNT_W(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSEL_1(hsel_1), .HSEL_2(hsel_2), .HSEL_3(hsel_3), .HSEL_DF(hsel_df),
    .HTRANS(htrans),
    .HRDATA_1(rdata_1), .HRDATA_2(rdata_2), .HRDATA_3(rdata_3),
    .HREADYOUT_1(ready_1), .HREADYOUT_2(ready_2), .HREADYOUT_3(ready_3),
    .HRESP_1(resp_1), .HRESP_2(resp_2), .HRESP_3(resp_3),
    .HRDATA(hrdata), .HREADY(hready), .HRESP(hresp), .ERR_CNT(err_cnt)
  );

  ahb_slave_mux #(.DATA_W(32), .ERR_CNT_W(2)) dut_sat (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HSEL_1(hsel_1), .HSEL_2(hsel_2), .HSEL_3(hsel_3), .HSEL_DF(hsel_df),
    .HTRANS(htrans),
    .HRDATA_1(rdata_1), .HRDATA_2(rdata_2), .HRDATA_3(rdata_3),
    .HREADYOUT_1(ready_1), .HREADYOUT_2(ready_2), .HREADYOUT_3(ready_3),
    .HRESP_1(resp_1), .HRESP_2(resp_2), .HRESP_3(resp_3),
    .HRDATA(hrdata_s), .HREADY(hready_s), .HRESP(hresp_s), .ERR_CNT(err_cnt_s)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic void exp_out(output logic [31:0] d, output logic r, output logic e);
    case (m_tgt)
      1:       begin d = rdata_1; r = ready_1; e = resp_1; end
      2:       begin d = rdata_2; r = ready_2; e = resp_2; end
      3:       begin d = rdata_3; r = ready_3; e = resp_3; end
      default: begin d = 32'd0; r = (m_err != 2); e = (m_err != 0); end
    endcase
  endfunction

  function automatic int exp_sat();
    return (m_cnt > 3) ? 3 : m_cnt;
  endfunction

  // Advance one clock and the model alongside it; returns at posedge + 1.
  task automatic tick();
    logic [31:0] d;
    logic r, e;
    int w;
    exp_out(d, r, e);
    @(posedge HCLK);
    if (r) begin
      w = hsel_1 ? 1 : hsel_2 ? 2 : hsel_3 ? 3 : 0;
      m_tgt = w;
      if (w == 0 && htrans[1]) begin
        m_err = 2;
        m_cnt = m_cnt + 1;
      end else begin
        m_err = 0;
      end
    end else if (m_err == 2) begin
      m_err = 1;
    end
    #1;
  endtask

  task automatic drive_idle();
    hsel_1 = 0; hsel_2 = 0; hsel_3 = 0; hsel_df = 0; htrans = 2'b00;
  endtask

  task automatic model_reset();
    m_tgt = 0; m_err = 0; m_cnt = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    rdata_1 = 32'h1111_1111; rdata_2 = 32'h2222_2222; rdata_3 = 32'h3333_3333;
    ready_1 = 1; ready_2 = 1; ready_3 = 1;
    resp_1 = 0; resp_2 = 0; resp_3 = 0;
    HRESETn = 1;
    #13;
    HRESETn = 0;
    model_reset();
    #1;
    checks++;
    if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'd0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_async got rdy=%b resp=%b data=%h cnt=%0d exp rdy=1 resp=0 data=0 cnt=0",
               hready, hresp, hrdata, err_cnt);
    end
    @(negedge HCLK);
    HRESETn = 1;
    @(posedge HCLK);
    #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      checks++;
      if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'd0 || err_cnt !== 8'd0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got rdy=%b resp=%b data=%h cnt=%0d exp rdy=1 resp=0 data=0 cnt=0",
                 k, hready, hresp, hrdata, err_cnt);
      end
      tick();
    end
  endtask

  task automatic test_slave_wait();
    drive_idle();
    hsel_2 = 1; htrans = 2'b10;
    tick();
    drive_idle();
    htrans = 2'b10;
    rdata_2 = 32'hCAFEF00D;
    rdata_1 = $urandom;
    for (int k = 0; k < 3; k++) begin
      ready_2 = (k == 2);
      hsel_1 = k[0] ? 1'b0 : 1'b1;
      rdata_1 = $urandom;
      @(negedge HCLK);
      checks++;
      if (hready !== (k == 2) || hrdata !== 32'hCAFEF00D) begin
        errors++;
        $display("FAIL slave_wait cyc=%0d got rdy=%b data=%h exp rdy=%b data=cafef00d",
                 k, hready, hrdata, (k == 2));
      end
      tick();
    end
    ready_2 = 1;
    drive_idle();
  endtask

  task automatic test_unmapped_error();
    int start_cnt;
    start_cnt = m_cnt;
    drive_idle();
    hsel_df = 1; htrans = 2'b10;
    tick();
    drive_idle();
    @(negedge HCLK);
    checks++;
    if (hready !== 1'b0 || hresp !== 1'b1 || hrdata !== 32'd0) begin
      errors++;
      $display("FAIL df_err1 got rdy=%b resp=%b data=%h exp rdy=0 resp=1 data=0", hready, hresp, hrdata);
    end
    tick();
    @(negedge HCLK);
    checks++;
    if (hready !== 1'b1 || hresp !== 1'b1 || int'(err_cnt) != start_cnt + 1) begin
      errors++;
      $display("FAIL df_err2 got rdy=%b resp=%b cnt=%0d exp rdy=1 resp=1 cnt=%0d",
               hready, hresp, err_cnt, start_cnt + 1);
    end
    tick();
  endtask

  task automatic test_unmapped_idle();
    int start_cnt;
    start_cnt = m_cnt;
    for (int k = 0; k < 2; k++) begin
      drive_idle();
      hsel_df = 1; htrans = (k == 0) ? 2'b00 : 2'b01;
      tick();
      drive_idle();
      @(negedge HCLK);
      checks++;
      if (hready !== 1'b1 || hresp !== 1'b0 || hrdata !== 32'd0 || int'(err_cnt) != start_cnt) begin
        errors++;
        $display("FAIL df_idle htrans=%b got rdy=%b resp=%b data=%h cnt=%0d exp rdy=1 resp=0 data=0 cnt=%0d",
                 (k == 0) ? 2'b00 : 2'b01, hready, hresp, hrdata, err_cnt, start_cnt);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int start_cnt;
    drive_idle();
    hsel_df = 1; htrans = 2'b10;
    tick();
    drive_idle();
    htrans = 2'b11;
    @(negedge HCLK);
    checks++;
    if (hready !== 1'b0 || hresp !== 1'b1) begin
      errors++;
      $display("FAIL b2b_err1 got rdy=%b resp=%b exp rdy=0 resp=1", hready, hresp);
    end
    tick();
    hsel_1 = 1; htrans = 2'b10;
    rdata_1 = 32'hA5A5_0001; ready_1 = 1; resp_1 = 0;
    @(negedge HCLK);
    checks++;
    if (hready !== 1'b1 || hresp !== 1'b1) begin
      errors++;
      $display("FAIL b2b_err2 got rdy=%b resp=%b exp rdy=1 resp=1", hready, hresp);
    end
    tick();
    drive_idle();
    @(negedge HCLK);
    checks++;
    if (hrdata !== 32'hA5A5_0001 || hready !== 1'b1 || hresp !== 1'b0) begin
      errors++;
      $display("FAIL b2b_slave1 got data=%h rdy=%b resp=%b exp data=a5a50001 rdy=1 resp=0",
               hrdata, hready, hresp);
    end
    tick();
    // Two unmapped accesses back to back: ERR1, ERR2, ERR1, ERR2.
    start_cnt = m_cnt;
    hsel_df = 1; htrans = 2'b10;
    tick();
    for (int k = 0; k < 4; k++) begin
      hsel_df = (k < 2); htrans = (k < 2) ? 2'b11 : 2'b00;
      @(negedge HCLK);
      checks++;
      if (hready !== k[0] || hresp !== 1'b1) begin
        errors++;
        $display("FAIL b2b_unmapped cyc=%0d got rdy=%b resp=%b exp rdy=%b resp=1", k, hready, hresp, k[0]);
      end
      tick();
    end
    @(negedge HCLK);
    checks++;
    if (int'(err_cnt) != start_cnt + 2) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=%0d", err_cnt, start_cnt + 2);
    end
    drive_idle();
    tick();
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic r, e;
    for (int k = 0; k < 400; k++) begin
      {hsel_1, hsel_2, hsel_3, hsel_df} = 4'($urandom);
      htrans  = 2'($urandom);
      rdata_1 = $urandom; rdata_2 = $urandom; rdata_3 = $urandom;
      ready_1 = ($urandom_range(0, 3) != 0);
      ready_2 = ($urandom_range(0, 3) != 0);
      ready_3 = ($urandom_range(0, 3) != 0);
      resp_1  = 1'($urandom); resp_2 = 1'($urandom); resp_3 = 1'($urandom);
      @(negedge HCLK);
      exp_out(d, r, e);
      checks++;
      if (hrdata !== d || hready !== r || hresp !== e) begin
        errors++;
        $display("FAIL rand_out cyc=%0d got data=%h rdy=%b resp=%b exp data=%h rdy=%b resp=%b",
                 k, hrdata, hready, hresp, d, r, e);
      end
      checks++;
      if (int'(err_cnt) != m_cnt || int'(err_cnt_s) != exp_sat()) begin
        errors++;
        $display("FAIL rand_cnt cyc=%0d got cnt=%0d sat=%0d exp cnt=%0d sat=%0d",
                 k, err_cnt, err_cnt_s, m_cnt, exp_sat());
      end
      tick();
    end
    drive_idle();
    ready_1 = 1; ready_2 = 1; ready_3 = 1;
    resp_1 = 0; resp_2 = 0; resp_3 = 0;
    // Drain any outstanding data phase before the next scenario.
    for (int k = 0; k < 3; k++) tick();
  endtask

  task automatic test_saturation();
    #2;
    HRESETn = 0;
    model_reset();
    @(negedge HCLK);
    HRESETn = 1;
    @(posedge HCLK);
    #1;
    for (int a = 1; a <= 5; a++) begin
      drive_idle();
      hsel_df = 1; htrans = 2'b10;
      tick();
      drive_idle();
      tick();
      @(negedge HCLK);
      checks++;
      if (int'(err_cnt_s) != ((a > 3) ? 3 : a) || int'(err_cnt) != a) begin
        errors++;
        $display("FAIL sat_count access=%0d got sat=%0d cnt=%0d exp sat=%0d cnt=%0d",
                 a, err_cnt_s, err_cnt, (a > 3) ? 3 : a, a);
      end
      tick();
    end
    // Reset while the default slave is stalling the bus.
    hsel_df = 1; htrans = 2'b10;
    tick();
    drive_idle();
    #2;
    checks++;
    if (hready !== 1'b0 || hresp !== 1'b1) begin
      errors++;
      $display("FAIL sat_pre_reset got rdy=%b resp=%b exp rdy=0 resp=1", hready, hresp);
    end
    HRESETn = 0;
    model_reset();
    #1;
    checks++;
    if (hready !== 1'b1 || hresp !== 1'b0 || err_cnt !== 8'd0 || err_cnt_s !== 2'd0 || hrdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_in_err1 got rdy=%b resp=%b cnt=%0d sat=%0d data=%h exp rdy=1 resp=0 cnt=0 sat=0 data=0",
               hready, hresp, err_cnt, err_cnt_s, hrdata);
    end
    @(negedge HCLK);
    HRESETn = 1;
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    test_reset();
    test_slave_wait();
    test_unmapped_error();
    test_unmapped_idle();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
